// File: rtl/id_pkg.sv
// id_pkg: shared decode constants and ID/EX bundle type for id_stage.
// Opcodes, immediate formats, branch funct3 codes, NOP word, immediate helper.
package id_pkg;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [31:0] insn;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } id_ex_t;

   function automatic logic [31:0] imm_gen(
      input logic [31:0] w,
      input imm_fmt_t    f
   );
      logic [31:0] r;
      r = '0;
      unique case (f)
         IMM_I: r = {{20{w[31]}}, w[31:20]};
         IMM_S: r = {{20{w[31]}}, w[31:25], w[11:7]};
         IMM_B: r = {{19{w[31]}}, w[31], w[7],
                     w[30:25], w[11:8], 1'b0};
         IMM_U: r = {w[31:12], 12'b0};
         IMM_J: r = {{11{w[31]}}, w[31], w[19:12],
                     w[20], w[30:21], 1'b0};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic br_cmp(
      input logic [2:0]  f3,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic t;
      t = 1'b0;
      unique case (f3)
         F3_BEQ:  t = (a == b);
         F3_BNE:  t = (a != b);
         F3_BLT:  t = ($signed(a) < $signed(b));
         F3_BGE:  t = ($signed(a) >= $signed(b));
         F3_BLTU: t = (a < b);
         F3_BGEU: t = (a >= b);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: 32x32 integer registers, x0 tied to zero, async clear.
// Ports: clk, reset_n, one write port (we/wa/wd), two bypassed reads.
module id_regfile
   import id_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] mem [32];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (wa != 5'd0)) begin
         mem[wa] <= wd;
      end
   end

   // Write-through: a same-cycle write is visible to the reader.
   always_comb begin
      rd1 = '0;
      if (ra1 != 5'd0) begin
         rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
      end
   end

   always_comb begin
      rd2 = '0;
      if (ra2 != 5'd0) begin
         rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
      end
   end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, register read, JAL/JALR redirect, ID/EX register.
// In: clk, reset_n, pipe_pc/pc4/data, wb_en/rd/data. Out: control_j, pc_j,
// ex_* bundle. Define ID_BRANCH_EN to resolve conditional branches in ID.
module id_stage
   import id_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pipe_pc,
   input  logic [31:0] pipe_pc4,
   input  logic [31:0] pipe_data,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        control_j,
   output logic [31:0] pc_j,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_pc4,
   output logic [31:0] ex_rs1_data,
   output logic [31:0] ex_rs2_data,
   output logic [31:0] ex_imm,
   output logic [31:0] ex_insn,
   output logic [4:0]  ex_rd,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2
);

   localparam id_ex_t BUBBLE = '{
      valid:    1'b0,
      pc:       32'd0,
      pc4:      32'd0,
      rs1_data: 32'd0,
      rs2_data: 32'd0,
      imm:      32'd0,
      insn:     NOP_WORD,
      rd:       5'd0,
      rs1:      5'd0,
      rs2:      5'd0
   };

   logic [6:0]  opc;
   logic [4:0]  rd_idx;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        sq_q;
   logic        op_ok;
   logic        is_jal;
   logic        is_jalr;
   logic        br_f3_ok;
   logic        br_take;
   logic        insn_ok;
   imm_fmt_t    fmt;
   logic [31:0] imm;
   logic [31:0] tgt_pc;
   logic [31:0] tgt_reg;
   id_ex_t      ex_d;
   id_ex_t      ex_q;

   assign opc     = pipe_data[6:0];
   assign rd_idx  = pipe_data[11:7];
   assign rs1_idx = pipe_data[19:15];
   assign rs2_idx = pipe_data[24:20];

   id_regfile u_rf (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wb_en),
      .wa      (wb_rd),
      .wd      (wb_data),
      .ra1     (rs1_idx),
      .ra2     (rs2_idx),
      .rd1     (rs1_data),
      .rd2     (rs2_data)
   );

`ifdef ID_BRANCH_EN
   logic [2:0] funct3;
   logic       is_br;
   assign funct3   = pipe_data[14:12];
   assign is_br    = (opc == OPC_BRANCH);
   // SLT-style funct3 codes are not branches.
   assign br_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
   assign br_take  = is_br && br_f3_ok &&
                     br_cmp(funct3, rs1_data, rs2_data);
`else
   assign br_f3_ok = 1'b1;
   assign br_take  = 1'b0;
`endif

   always_comb begin
      op_ok   = 1'b0;
      is_jal  = 1'b0;
      is_jalr = 1'b0;
      fmt     = IMM_NONE;
      unique case (1'b1)
         (opc == OPC_LUI),
         (opc == OPC_AUIPC): begin
            op_ok = 1'b1;
            fmt   = IMM_U;
         end
         (opc == OPC_JAL): begin
            op_ok  = 1'b1;
            is_jal = 1'b1;
            fmt    = IMM_J;
         end
         (opc == OPC_JALR): begin
            op_ok   = 1'b1;
            is_jalr = 1'b1;
            fmt     = IMM_I;
         end
         (opc == OPC_BRANCH): begin
            op_ok = br_f3_ok;
            fmt   = IMM_B;
         end
         (opc == OPC_LOAD),
         (opc == OPC_OPIMM),
         (opc == OPC_MISC),
         (opc == OPC_SYSTEM): begin
            op_ok = 1'b1;
            fmt   = IMM_I;
         end
         (opc == OPC_STORE): begin
            op_ok = 1'b1;
            fmt   = IMM_S;
         end
         (opc == OPC_OP): begin
            op_ok = 1'b1;
            fmt   = IMM_NONE;
         end
         default: begin
            op_ok = 1'b0;
         end
      endcase
   end

   // The slot after a redirect is wrong-path: it decodes as a bubble.
   assign insn_ok = op_ok && !sq_q;
   assign imm     = imm_gen(pipe_data, fmt);
   assign tgt_pc  = pipe_pc + imm;
   assign tgt_reg = (rs1_data + imm) & ~32'd1;

   assign control_j = insn_ok && (is_jal || is_jalr || br_take);
   assign pc_j      = !control_j ? 32'd0 :
                      is_jalr    ? tgt_reg : tgt_pc;

   always_comb begin
      ex_d = BUBBLE;
      if (insn_ok) begin
         ex_d.valid    = 1'b1;
         ex_d.pc       = pipe_pc;
         ex_d.pc4      = pipe_pc4;
         ex_d.rs1_data = rs1_data;
         ex_d.rs2_data = rs2_data;
         ex_d.imm      = imm;
         ex_d.insn     = pipe_data;
         ex_d.rd       = rd_idx;
         ex_d.rs1      = rs1_idx;
         ex_d.rs2      = rs2_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_q <= BUBBLE;
         sq_q <= 1'b0;
      end else begin
         ex_q <= ex_d;
         sq_q <= control_j;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_pc       = ex_q.pc;
   assign ex_pc4      = ex_q.pc4;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_imm      = ex_q.imm;
   assign ex_insn     = ex_q.insn;
   assign ex_rd       = ex_q.rd;
   assign ex_rs1      = ex_q.rs1;
   assign ex_rs2      = ex_q.rs2;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed checks of id_stage against an ISA-level model.
// Model predicts redirect and ID/EX bundle from opcode rules and a reg array.
module tb_id_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] pipe_pc = '0;
   logic [31:0] pipe_pc4 = 32'd4;
   logic [31:0] pipe_data = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        control_j;
   logic [31:0] pc_j;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_pc4, ex_rs1_data, ex_rs2_data;
   logic [31:0] ex_imm, ex_insn;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;

   id_stage dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pipe_pc     (pipe_pc),
      .pipe_pc4    (pipe_pc4),
      .pipe_data   (pipe_data),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .control_j   (control_j),
      .pc_j        (pc_j),
      .ex_valid    (ex_valid),
      .ex_pc       (ex_pc),
      .ex_pc4      (ex_pc4),
      .ex_rs1_data (ex_rs1_data),
      .ex_rs2_data (ex_rs2_data),
      .ex_imm      (ex_imm),
      .ex_insn     (ex_insn),
      .ex_rd       (ex_rd),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- model ----------------
   logic [31:0] mreg [32];
   logic        msq;
   logic        e_valid;
   logic [31:0] e_pc, e_pc4, e_r1, e_r2, e_imm, e_insn;
   logic [4:0]  e_rd, e_rs1, e_rs2;

   typedef struct packed {
      logic        ok;
      logic        redir;
      logic [31:0] tgt;
      logic [31:0] imm;
      logic [31:0] a;
      logic [31:0] b;
   } pred_t;

   pred_t cur;

   function automatic logic [31:0] rd_reg(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_en && wb_rd == r) return wb_data;
      return mreg[r];
   endfunction

   function automatic pred_t predict();
      pred_t p;
      logic [31:0] w;
      logic signed [31:0] t;
      logic tk;
      w = pipe_data;
      p = '0;
      tk = 1'b0;
      p.a = rd_reg(w[19:15]);
      p.b = rd_reg(w[24:20]);
      case (w[6:0])
         7'h37, 7'h17: begin
            p.ok = 1'b1;
            p.imm = {w[31:12], 12'h000};
         end
         7'h6F: begin
            p.ok = 1'b1;
            t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0};
            p.imm = t >>> 11;
            p.redir = 1'b1;
            p.tgt = pipe_pc + p.imm;
         end
         7'h67: begin
            p.ok = 1'b1;
            t = w;
            p.imm = t >>> 20;
            p.redir = 1'b1;
            p.tgt = (p.a + p.imm) & 32'hFFFF_FFFE;
         end
         7'h03, 7'h13, 7'h0F, 7'h73: begin
            p.ok = 1'b1;
            t = w;
            p.imm = t >>> 20;
         end
         7'h23: begin
            p.ok = 1'b1;
            t = {w[31:25], w[11:7], 20'b0};
            p.imm = t >>> 20;
         end
         7'h33: p.ok = 1'b1;
         7'h63: begin
            t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0};
            p.imm = t >>> 19;
`ifdef ID_BRANCH_EN
            p.ok = 1'b1;
            case (w[14:12])
               3'd0: tk = (p.a == p.b);
               3'd1: tk = (p.a != p.b);
               3'd4: tk = ($signed(p.a) < $signed(p.b));
               3'd5: tk = ($signed(p.a) >= $signed(p.b));
               3'd6: tk = (p.a < p.b);
               3'd7: tk = (p.a >= p.b);
               default: p.ok = 1'b0;
            endcase
            if (p.ok && tk) begin
               p.redir = 1'b1;
               p.tgt = pipe_pc + p.imm;
            end
`else
            p.ok = 1'b1;
`endif
         end
         default: p.ok = 1'b0;
      endcase
      if (msq || !p.ok) begin
         p.ok = 1'b0;
         p.redir = 1'b0;
      end
      if (!p.redir) p.tgt = 32'd0;
      return p;
   endfunction

   always_comb cur = predict();

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         msq <= 1'b0;
         for (int i = 0; i < 32; i++) mreg[i] <= 32'd0;
         e_valid <= 1'b0; e_insn <= NOP;
         e_pc <= 0; e_pc4 <= 0; e_r1 <= 0; e_r2 <= 0; e_imm <= 0;
         e_rd <= 0; e_rs1 <= 0; e_rs2 <= 0;
      end else begin
         msq <= cur.redir;
         if (wb_en && wb_rd != 5'd0) mreg[wb_rd] <= wb_data;
         e_valid <= cur.ok;
         e_insn <= cur.ok ? pipe_data : NOP;
         e_pc   <= cur.ok ? pipe_pc : 32'd0;
         e_pc4  <= cur.ok ? pipe_pc4 : 32'd0;
         e_r1   <= cur.ok ? cur.a : 32'd0;
         e_r2   <= cur.ok ? cur.b : 32'd0;
         e_imm  <= cur.ok ? cur.imm : 32'd0;
         e_rd   <= cur.ok ? pipe_data[11:7] : 5'd0;
         e_rs1  <= cur.ok ? pipe_data[19:15] : 5'd0;
         e_rs2  <= cur.ok ? pipe_data[24:20] : 5'd0;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (run) begin
         chk("control_j", {31'd0, control_j}, {31'd0, cur.redir});
         chk("pc_j", pc_j, cur.tgt);
         chk("ex_valid", {31'd0, ex_valid}, {31'd0, e_valid});
         chk("ex_pc", ex_pc, e_pc);
         chk("ex_pc4", ex_pc4, e_pc4);
         chk("ex_rs1_data", ex_rs1_data, e_r1);
         chk("ex_rs2_data", ex_rs2_data, e_r2);
         chk("ex_imm", ex_imm, e_imm);
         chk("ex_insn", ex_insn, e_insn);
         chk("ex_rd", {27'd0, ex_rd}, {27'd0, e_rd});
         chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, e_rs1});
         chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, e_rs2});
      end
   end

   // ---------------- stimulus ----------------
   task automatic put(input logic [31:0] pc, input logic [31:0] w,
                      input logic we = 1'b0, input logic [4:0] rd = 5'd0,
                      input logic [31:0] wd = 32'd0);
      pipe_pc = pc;
      pipe_pc4 = pc + 32'd4;
      pipe_data = w;
      wb_en = we;
      wb_rd = rd;
      wb_data = wd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] vec [16] = '{
      32'hFFF28193, 32'h00512223, 32'h123453B7, 32'h00001297,
      32'h0000000F, 32'h00000073, 32'hFFFFFFFF, 32'h00000040,
      32'h0022C463, 32'h0022E463, 32'h0022D463, 32'h0022F463,
      32'hFE029EE3, 32'h0022A463, 32'h00C28267, 32'h000280B3
   };

   initial begin
      #1;
      reset_n = 1'b0;
      run = 1'b1;
      put(32'h0, 32'd64);
      chk("rst_cj", {31'd0, control_j}, 32'd0);
      tick();
      tick();
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_insn", ex_insn, 32'h13);
      chk("rst_rs1d", ex_rs1_data, 32'd0);
      chk("rst_imm", ex_imm, 32'd0);
      reset_n = 1'b1;

      put(32'h100, 32'h000280B3, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      chk("byp_rs1d", ex_rs1_data, 32'hDEADBEEF);
      chk("byp_rd", {27'd0, ex_rd}, 32'd1);
      chk("byp_valid", {31'd0, ex_valid}, 32'd1);
      put(32'h104, 32'h000280B3);
      tick();
      chk("x5_kept", ex_rs1_data, 32'hDEADBEEF);

      put(32'h108, 32'h0, 1'b1, 5'd2, 32'h101);
      tick();
      chk("zero_word", {31'd0, ex_valid}, 32'd0);

      put(32'h80, 32'h00810067);
      chk("jalr_cj", {31'd0, control_j}, 32'd1);
      chk("jalr_pcj", pc_j, 32'h108);
      tick();
      put(32'h84, 32'h0100006F);
      chk("jalr_sq_cj", {31'd0, control_j}, 32'd0);
      tick();
      chk("jalr_sq_valid", {31'd0, ex_valid}, 32'd0);

      put(32'h40, 32'h0100006F);
      chk("jal_cj", {31'd0, control_j}, 32'd1);
      chk("jal_pcj", pc_j, 32'h50);
      tick();
      put(32'h44, 32'h000280B3);
      chk("jal_sq_cj", {31'd0, control_j}, 32'd0);
      tick();
      chk("jal_sq_valid", {31'd0, ex_valid}, 32'd0);
      chk("jal_sq_insn", ex_insn, 32'h13);

      put(32'h60, 32'h00108463);
`ifdef ID_BRANCH_EN
      chk("br_cj", {31'd0, control_j}, 32'd1);
      chk("br_pcj", pc_j, 32'h68);
      tick();
      put(32'h64, 32'h000280B3);
      tick();
      chk("br_sq_valid", {31'd0, ex_valid}, 32'd0);
`else
      chk("br_cj", {31'd0, control_j}, 32'd0);
      tick();
      chk("br_imm", ex_imm, 32'd8);
      chk("br_valid", {31'd0, ex_valid}, 32'd1);
`endif

      put(32'h200, 32'h00000093, 1'b1, 5'd0, 32'h1234);
      tick();
      chk("x0_same", ex_rs1_data, 32'd0);
      put(32'h204, 32'h00000093);
      tick();
      chk("x0_read", ex_rs1_data, 32'd0);

      put(32'h1000, 32'hFF9FF06F);
      chk("jal_neg_pcj", pc_j, 32'hFF8);
      tick();
      put(32'h1004, 32'h00000013);
      tick();

      put(32'h300, 32'h0100006F);
      tick();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      put(32'h304, 32'h0100006F);
      chk("rst_mid_cj", {31'd0, control_j}, 32'd1);
      chk("rst_mid_pcj", pc_j, 32'h314);
      tick();
      put(32'h314, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();

      put(32'h400, 32'h00810067, 1'b1, 5'd2, 32'h500);
      chk("jw_pcj", pc_j, 32'h508);
      tick();
      put(32'h404, 32'h0);
      tick();
      put(32'h508, 32'h00010033);
      tick();
      chk("jw_x2", ex_rs1_data, 32'h500);

      put(32'h600, 32'hFFF28193);
      tick();
      chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
      put(32'h604, 32'h00512223);
      tick();
      chk("sw_imm", ex_imm, 32'd4);
      put(32'h608, 32'h123453B7);
      tick();
      chk("lui_imm", ex_imm, 32'h1234_5000);

      for (int i = 0; i < 16; i++) begin
         put(32'h700 + 32'(i) * 4, vec[i], (i % 3) == 0,
             5'(10 + (i % 8)), 32'hA5A5_0000 + 32'(i) * 32'h1111);
         tick();
      end
      put(32'h800, 32'h0);
      tick();
      run = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 32-bit RISC-V pipeline and the consumer end of the fetch interface. Accepts `pipe_pc`, `pipe_pc4` and `pipe_data` from fetch, and returns the redirect pair `control_j`/`pc_j`. Holds the 32x32 integer register file and emits a registered ID/EX bundle. Resolves JAL/JALR, and optionally conditional branches, in ID and squashes the single wrong-path instruction that follows a redirect.

## Interface
- `NOP_WORD`, default `32'h0000_0013`: word presented on the bubble path (`addi x0,x0,0`).
- `clk` in 1: clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pipe_pc` in 32: PC of the instruction in ID.
- `pipe_pc4` in 32: `pipe_pc`+4.
- `pipe_data` in 32: instruction word.
- `wb_en` in 1: register write enable from write-back.
- `wb_rd` in 5: write-back destination register.
- `wb_data` in 32: write-back data.
- `control_j` out 1: redirect request to fetch. Combinational.
- `pc_j` out 32: redirect target. Combinational; 0 when `control_j`=0.
- `ex_valid` out 1: ID/EX bundle holds a real instruction.
- `ex_pc`, `ex_pc4`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm` out 32: registered ID/EX bundle.
- `ex_insn` out 32: registered ID/EX bundle; carries `NOP_WORD` on a bubble.
- `ex_rd`, `ex_rs1`, `ex_rs2` out 5: register indices.

## Operation
- **Valid decode.** An instruction is valid when its opcode is one of the RV32I opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM. Any other word, including 0 and 64, is a bubble.
- **Squash.** The squash flag `sq_q` is set on an edge when `control_j`=1 and is otherwise cleared. While `sq_q`=1, the word in ID is forced to a bubble and cannot redirect.
- **Bubble bundle.** On a bubble: `ex_valid`=0, `ex_insn`=`NOP_WORD`, and all other `ex_*` fields 0.
- **Immediates.** I, S, B, U and J formats, sign-extended to 32 bits. R-type gives an immediate of 0.
- **Register file reads.** `x0` reads 0, and writes to `x0` are dropped.
  - Write-through bypass: if `wb_en` and `wb_rd`==rs and rs!=0, the read returns `wb_data` in the same cycle.
- **JAL.** `control_j`=1; `pc_j`=`pipe_pc`+immJ.
- **JALR.** `control_j`=1; `pc_j`=(rs1_data+immI) & ~1, using bypassed rs1.
- **Arithmetic.** All adds are modulo 2^32; wrap-around is silent.
- **Priority.** Squash overrides decode, and reset overrides everything.

## Timing
- **Reset state.** While `reset_n`=0:
  - every `ex_*` output is 0 except `ex_insn`=`NOP_WORD`, and `ex_valid`=0;
  - `sq_q`=0 and all 32 registers are 0.
- **Redirect path.** `control_j`/`pc_j` are valid in the same cycle as `pipe_data` (zero-latency combinational path). Fetch loads `pc_j` at the next edge.
- **Redirect sequence.** Redirect at edge N. The word latched by fetch at edge N is squashed in cycle N+1. The target's word arrives at ID at N+2. Back-to-back redirects are impossible because the squashed slot cannot redirect.
- **ID/EX latency.** The bundle is updated every edge (no stall input), giving 1-cycle ID to EX latency.
- **Simultaneous events.**
  - Write and read of the same register in the same cycle: the bundle captures the new value.
  - Redirect plus write-back in the same cycle: both take effect.
- **Reset mid-redirect.** `reset_n` deasserting between a redirect and its squash clears `sq_q`, so nothing is squashed after reset.

## Configuration
- **With `ID_BRANCH_EN` defined:** BRANCH opcodes (BEQ, BNE, BLT, BGE, BLTU, BGEU) compare bypassed rs1/rs2 in ID.
  - Taken: `control_j`=1, `pc_j`=`pipe_pc`+immB, and the squash sequence applies.
  - Not taken: `control_j`=0.
  - `funct3` 010/011 are treated as bubbles.
- **Without it:** branches never redirect from ID. They pass to EX as valid instructions with `ex_imm`=immB.

## Structure
- **Package `id_pkg`:**
  - 7-bit opcode constants;
  - `imm_fmt_t` enum (I/S/B/U/J/NONE);
  - branch `funct3` constants;
  - `NOP_WORD` default.
- **Sub-module `id_regfile`:** 32x32 storage with asynchronous reset to 0, two combinational read ports with write-through bypass, one write port, and `x0` hard-wired to zero.
- `id_stage` keeps the decode, immediate, redirect, squash and ID/EX register logic.

## Test plan
- **Reset.** Hold `reset_n`=0 with `pipe_data`=64 → `control_j`=0, `ex_valid`=0, `ex_insn`=`32'h13`, all other `ex_*` 0.
- **Bypass.** `wb_en`=1, `wb_rd`=5, `wb_data`=`32'hDEADBEEF`, same cycle `pipe_data`=`32'h000280B3` → next edge `ex_rs1_data`=`32'hDEADBEEF`, `ex_rd`=1, `ex_valid`=1.
- **JAL and squash.** `pipe_pc`=`32'h40`, `pipe_data`=`32'h0100006F` → same cycle `control_j`=1, `pc_j`=`32'h50`; following cycle `ex_valid`=0, `control_j`=0 for any word.
- **JALR.** x2=`32'h101`, `pipe_data`=`32'h00810067` → `pc_j`=`32'h108`.
- **Branch.** `pipe_pc`=`32'h60`, `pipe_data`=`32'h00108463`:
  - with `ID_BRANCH_EN` → `control_j`=1, `pc_j`=`32'h68`;
  - without → `control_j`=0, `ex_imm`=8.
- **x0 and zero word.** Write x0=`32'h1234` then read x0 → `ex_rs1_data`=0; `pipe_data`=0 → `ex_valid`=0.
